sr_latch_ctrl: RTL

Sequencing controller and two-requester arbiter for a bank of cross-coupled NAND SR latches. Converts clocked set/reset requests into bounded active-low strobes, never drives the forbidden S=R=0 input on any latch, inserts a settle guard after every strobe, and verifies the latch output against the expected state. Sits between synchronous control logic and the asynchronous latch bank, which has no clock of its own.

---
 rtl/sr_latch_ctrl_if.sv | 11 +
 rtl/sr_latch_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/sr_latch_ctrl_if.sv
// sr_latch_ctrl_if: two-requester handshake bundle (req/op/idx toward the controller, ack back)
interface sr_latch_ctrl_if #(
    parameter int IW = 2
);
    logic [1:0]      req;
    logic [1:0]      op;
    logic [2*IW-1:0] idx;
    logic [1:0]      ack;
    modport master (output req, op, idx, input ack);
    modport slave  (input req, op, idx, output ack);
endinterface

// File: rtl/sr_latch_ctrl.sv
// sr_latch_ctrl: arbitrated, guarded strobe sequencer for a bank of NAND SR latches
module sr_latch_ctrl #(
    parameter int N_LATCH = 4,
    parameter int PULSE_W = 2,
    parameter int GUARD_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    sr_latch_ctrl_if.slave     rq,
    input  logic [N_LATCH-1:0] q_fb,
    output logic [N_LATCH-1:0] s_n,
    output logic [N_LATCH-1:0] r_n,
    output logic               busy,
    output logic [N_LATCH-1:0] shadow,
    output logic               err,
    output logic               err_sticky
);
    localparam int IW = $clog2(N_LATCH);
    localparam int CW = $clog2((PULSE_W > GUARD_W ? PULSE_W : GUARD_W) + 1);

    typedef enum logic [2:0] {INIT, INIT_GUARD, IDLE, PULSE, GUARD, CHECK} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic               rr;
    logic               cw;
    logic               cop;
    logic [IW-1:0]      cidx;
    logic [N_LATCH-1:0] q_meta;
    logic [N_LATCH-1:0] q_sync;
    logic               w;
    logic               wop;
    logic [IW-1:0]      widx;
    logic [N_LATCH-1:0] wmask;

    // two-flop synchronizer for the asynchronous latch outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_meta <= '0;
            q_sync <= '0;
        end else begin
            q_meta <= q_fb;
            q_sync <= q_meta;
        end
    end

    // pick the winner: a lone request wins, contention goes to the round-robin pointer
    always_comb begin
        w     = &rq.req ? rr : rq.req[1];
        wop   = rq.op[w];
        widx  = w ? rq.idx[2*IW-1:IW] : rq.idx[IW-1:0];
        wmask = N_LATCH'(1) << widx;
    end

    // sequencer: every strobe is followed by an all-high guard before anything else moves
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= INIT;
            cnt        <= '0;
            s_n        <= '1;
            r_n        <= '1;
            rq.ack     <= '0;
            busy       <= 1'b1;
            err        <= 1'b0;
            err_sticky <= 1'b0;
            shadow     <= '0;
            rr         <= 1'b0;
            cw         <= 1'b0;
            cop        <= 1'b0;
            cidx       <= '0;
        end else begin
            rq.ack <= '0;
            err    <= 1'b0;
            case (state)
                INIT: begin
                    if (cnt == CW'(PULSE_W)) begin
                        r_n   <= '1;
                        cnt   <= '0;
                        state <= INIT_GUARD;
                    end else begin
                        r_n <= '0;
                        cnt <= cnt + 1'b1;
                    end
                end
                INIT_GUARD: begin
                    if (cnt == CW'(GUARD_W - 2)) begin
                        err        <= |q_sync;
                        err_sticky <= err_sticky | (|q_sync);
                    end
                    if (cnt == CW'(GUARD_W - 1)) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (|rq.req) begin
                        rr     <= ~w;
                        cw     <= w;
                        cop    <= wop;
                        cidx   <= widx;
                        shadow <= wop ? (shadow | wmask) : (shadow & ~wmask);
                        s_n    <= wop ? ~wmask : '1;
                        r_n    <= wop ? '1 : ~wmask;
                        busy   <= 1'b1;
                        cnt    <= '0;
                        state  <= PULSE;
                    end
                end
                PULSE: begin
                    if (cnt == CW'(PULSE_W - 1)) begin
                        s_n   <= '1;
                        r_n   <= '1;
                        cnt   <= '0;
                        state <= GUARD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GUARD: begin
                    if (cnt == CW'(GUARD_W - 1)) begin
                        rq.ack     <= cw ? 2'b10 : 2'b01;
                        err        <= q_sync[cidx] != cop;
                        err_sticky <= err_sticky | (q_sync[cidx] != cop);
                        cnt        <= '0;
                        state      <= CHECK;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CHECK: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= INIT;
            endcase
        end
    end
endmodule
